pipeline_unadd: RTL and testbench

- 4-stage pipelined 16-bit inverse adder: recovers the addend `a` from an adder result `{cout,sum}`, the other addend `b` and the carry-in `cin`.
- Computes `a = {cout,sum} - b - cin`, a 4-bit nibble per stage, with a valid/ready handshake on both sides.
- Sits downstream of the 16-bit pipelined adder. Used as a round-trip checker: the adder output is fed back here, and the recovered `a` is compared to the original.
- Flags any result outside 0..65535 as inconsistent.

---
 rtl/pipeline_unadd.sv | 60 ++++++
 tb/tb_pipeline_unadd.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_unadd.sv
// pipeline_unadd: 4-stage pipelined inverse adder, a = {cout,sum} - b - cin, one nibble per stage
// err flags a result outside 0..65535 (cout disagrees with the final borrow).
module pipeline_unadd (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] sum,
   input  logic        cout,
   input  logic [15:0] b,
   input  logic        cin,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] a,
   output logic        err
);
   logic adv1, adv2, adv3, adv4;
   logic [3:0] adv;
   assign adv = {adv4, adv3, adv2, adv1};
   for (genvar i = 0; i < 4; i++) begin : g
      logic v, c, w;
      logic [15:0] ra, rs, rb;
      logic pv, pc, pw;
      logic [15:0] pa, ps, pb;
      logic [4:0] d;
      if (i == 0) begin : src
         assign {pv, pc, pw, pa, ps, pb} = {in_valid, cout, cin, 16'd0, sum, b};
      end else begin : src
         assign {pv, pc, pw, pa, ps, pb} = {g[i-1].v, g[i-1].c, g[i-1].w, g[i-1].ra, g[i-1].rs, g[i-1].rb};
      end
      // 5-bit difference: bit 4 is the borrow-out of this nibble
      assign d = {1'b0, ps[4*i+:4]} - {1'b0, pb[4*i+:4]} - {4'd0, pw};
      always_ff @(posedge clk or negedge reset)
         if (!reset) begin
            v  <= 1'b0;
            c  <= 1'b0;
            w  <= 1'b0;
            ra <= '0;
            rs <= '0;
            rb <= '0;
         end else if (adv[i]) begin
            v <= pv;
            if (pv) begin
               c  <= pc;
               w  <= d[4];
               ra <= pa | (16'(d[3:0]) << (4*i));
               rs <= ps;
               rb <= pb;
            end
         end
   end
   assign adv4      = !g[3].v | out_ready;
   assign adv3      = !g[2].v | adv4;
   assign adv2      = !g[1].v | adv3;
   assign adv1      = !g[0].v | adv2;
   assign in_ready  = adv1;
   assign out_valid = g[3].v;
   assign a         = g[3].ra;
   assign err       = g[3].c ^ g[3].w;
endmodule

// File: tb/tb_pipeline_unadd.sv
// tb_pipeline_unadd: randomized and directed checks of pipeline_unadd against an arithmetic scoreboard
module tb_pipeline_unadd;
   logic clk, reset, in_valid, in_ready, cout, cin, out_valid, out_ready, err;
   logic [15:0] sum, b, a;

   pipeline_unadd dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .sum(sum), .cout(cout), .b(b), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready), .a(a), .err(err)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] s, bb;
      logic        co, ci;
      logic [16:0] ev;
   } beat_t;

   beat_t       pend[$];
   logic [16:0] expq[$];
   int checks = 0, errors = 0, nacc = 0, nout = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [16:0] unadd(logic [15:0] s, logic co, logic [15:0] bb, logic ci);
      int full;
      logic e;
      full = int'({co, s}) - int'(bb) - int'(ci);
      e = (full < 0) || (full > 65535);
      return {e, 16'(full)};
   endfunction

   task automatic push(input logic [15:0] s, input logic co, input logic [15:0] bb, input logic ci);
      beat_t x;
      x.s = s; x.co = co; x.bb = bb; x.ci = ci; x.ev = unadd(s, co, bb, ci);
      pend.push_back(x);
   endtask

   task automatic push_rand();
      beat_t x;
      logic [15:0] ao;
      ao = 16'($urandom);
      x.bb = 16'($urandom);
      x.ci = 1'($urandom);
      {x.co, x.s} = 17'(ao) + 17'(x.bb) + 17'(x.ci);
      x.ev = {1'b0, ao};
      pend.push_back(x);
   endtask

   // one clock: drive the head of pend, check any output transfer, update queues
   task automatic step();
      logic inf, outf;
      in_valid = pend.size() > 0;
      if (in_valid) {sum, cout, b, cin} = {pend[0].s, pend[0].co, pend[0].bb, pend[0].ci};
      @(negedge clk);
      inf  = in_valid && in_ready;
      outf = out_valid && out_ready;
      if (outf) begin
         if (expq.size() == 0) chk("spurious_out", 1, 0);
         else begin
            chk("a", 32'(a), 32'(expq[0][15:0]));
            chk("err", 32'(err), 32'(expq[0][16]));
         end
      end
      @(posedge clk);
      if (inf) begin
         expq.push_back(pend[0].ev);
         void'(pend.pop_front());
         nacc++;
      end
      if (outf) begin
         if (expq.size() > 0) void'(expq.pop_front());
         nout++;
      end
      #1;
   endtask

   initial begin
      int n0, o0, cyc;
      logic [15:0] sa;
      logic se, have;
      reset = 0; in_valid = 0; out_ready = 0;
      sum = 0; cout = 0; b = 0; cin = 0;
      #1;
      chk("rst_ov", 32'(out_valid), 0);
      chk("rst_ir", 32'(in_ready), 1);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_a", 32'(a), 0);
      chk("rst_err", 32'(err), 0);
      reset = 1;
      out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_ov", 32'(out_valid), 0);
         chk("idle_ir", 32'(in_ready), 1);
      end

      // basic round trip with latency check
      push(16'h2468, 0, 16'h1234, 0);
      o0 = nout;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("lat_ov_low", 32'(out_valid), 0);
      end
      step();
      chk("lat_ov_high", 32'(out_valid), 1);
      chk("basic_a", 32'(a), 32'h1234);
      step();
      chk("basic_one_cycle", 32'(out_valid), 0);
      chk("basic_count", nout - o0, 1);

      // carry, borrow and error corners
      push(16'h0000, 1, 16'hFFFF, 1);
      push(16'h0000, 0, 16'h0001, 0);
      push(16'h0005, 1, 16'h0000, 0);
      o0 = nout;
      repeat (8) step();
      chk("corner_count", nout - o0, 3);

      // back-pressure: 6 beats, consumer stalled for 8 cycles
      for (int i = 0; i < 6; i++) push(16'(i + 256), 0, 16'h00FF, 1);
      out_ready = 0;
      n0 = nacc;
      have = 0; sa = 0; se = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (out_valid && have) begin
            chk("stall_a", 32'(a), 32'(sa));
            chk("stall_err", 32'(err), 32'(se));
         end
         if (out_valid && !have) begin
            have = 1; sa = a; se = err;
         end
      end
      chk("bp_accepted", nacc - n0, 4);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_head_a", 32'(a), 0);
      out_ready = 1;
      o0 = nout;
      repeat (6) step();
      chk("bp_drain_rate", nout - o0, 6);
      chk("bp_drained", expq.size() + pend.size(), 0);

      // asynchronous reset with 3 beats in flight
      for (int i = 0; i < 3; i++) push(16'(i * 7 + 1), 0, 16'(i), 0);
      out_ready = 0;
      repeat (5) step();
      chk("mid_ov_before", 32'(out_valid), 1);
      #2 reset = 0;
      #1;
      chk("mid_ov_drop", 32'(out_valid), 0);
      chk("mid_ir", 32'(in_ready), 1);
      chk("mid_a", 32'(a), 0);
      expq.delete();
      pend.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1;
      out_ready = 1;
      o0 = nout;
      repeat (6) step();
      chk("mid_no_stale", nout - o0, 0);

      // random round trips through the adder model
      for (int i = 0; i < 1000; i++) push_rand();
      o0 = nout;
      cyc = 0;
      while ((pend.size() > 0 || expq.size() > 0) && cyc < 20000) begin
         out_ready = 1'($urandom);
         step();
         cyc++;
      end
      chk("rand_count", nout - o0, 1000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
